hci_cmd_dispatch: RTL and testbench

//  Downstream consumer of the HCI command queue: pops 64-bit PIO command descriptors, fetches the target's
//  DAT entry, and issues one decoded transfer request to the controller FSM. It then waits for completion
//  and pushes the 32-bit response descriptor into the HCI response queue.

---
 rtl/hci_cmd_dispatch_if.sv | 49 ++++
 rtl/hci_cmd_dispatch.sv | 204 ++++++++++++++++++++
 tb/tb_hci_cmd_dispatch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_cmd_dispatch_if.sv
// Handshake bundle between the HCI command dispatcher and its neighbours
// (command/response queues, DAT memory and the I3C controller FSM).
interface hci_cmd_dispatch_if #(
  parameter int DatIdxW = 7
);
  logic               cmd_rvalid_i;
  logic               cmd_rready_o;
  logic [63:0]        cmd_rdata_i;
  logic               dat_read_valid_o;
  logic [DatIdxW-1:0] dat_index_o;
  logic [63:0]        dat_rdata_i;
  logic               xfer_valid_o;
  logic               xfer_ready_i;
  logic [2:0]         xfer_attr_o;
  logic [3:0]         xfer_tid_o;
  logic [6:0]         xfer_addr_o;
  logic               xfer_i2c_o;
  logic               xfer_rnw_o;
  logic               xfer_cp_o;
  logic [7:0]         xfer_ccc_o;
  logic [15:0]        xfer_len_o;
  logic [31:0]        xfer_imm_o;
  logic               xfer_abort_o;
  logic               done_valid_i;
  logic [3:0]         done_err_i;
  logic [15:0]        done_len_i;
  logic               resp_wvalid_o;
  logic               resp_wready_i;
  logic [31:0]        resp_wdata_o;
  logic               busy_o;

  modport master (
    input  cmd_rvalid_i, cmd_rdata_i, dat_rdata_i, xfer_ready_i,
           done_valid_i, done_err_i, done_len_i, resp_wready_i,
    output cmd_rready_o, dat_read_valid_o, dat_index_o, xfer_valid_o,
           xfer_attr_o, xfer_tid_o, xfer_addr_o, xfer_i2c_o, xfer_rnw_o,
           xfer_cp_o, xfer_ccc_o, xfer_len_o, xfer_imm_o, xfer_abort_o,
           resp_wvalid_o, resp_wdata_o, busy_o
  );

  modport slave (
    output cmd_rvalid_i, cmd_rdata_i, dat_rdata_i, xfer_ready_i,
           done_valid_i, done_err_i, done_len_i, resp_wready_i,
    input  cmd_rready_o, dat_read_valid_o, dat_index_o, xfer_valid_o,
           xfer_attr_o, xfer_tid_o, xfer_addr_o, xfer_i2c_o, xfer_rnw_o,
           xfer_cp_o, xfer_ccc_o, xfer_len_o, xfer_imm_o, xfer_abort_o,
           resp_wvalid_o, resp_wdata_o, busy_o
  );
endinterface

// File: rtl/hci_cmd_dispatch.sv
// HCI command dispatcher: pops one PIO command, looks up the target in the DAT,
// issues a single transfer to the controller and pushes the response descriptor.
module hci_cmd_dispatch #(
  parameter int  DatDepth      = 128,
  parameter int  TimeoutCycles = 0,
  localparam int DatIdxW       = $clog2(DatDepth)
) (
  input logic               clk_i,
  input logic               rst_i,
  hci_cmd_dispatch_if.master bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DAT_RD    = 3'd1;
  localparam logic [2:0] ST_DAT_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE     = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [2:0]      state_q, state_d;
  logic [2:0]      attr_q, attr_d;
  logic [3:0]      tid_q, tid_d;
  logic [7:0]      ccc_q, ccc_d;
  logic            cp_q, cp_d;
  logic [4:0]      dev_idx_q, dev_idx_d;
  logic            rnw_q, rnw_d;
  logic            roc_q, roc_d;
  logic [15:0]     len_q, len_d;
  logic [31:0]     imm_q, imm_d;
  logic [6:0]      addr_q, addr_d;
  logic            i2c_q, i2c_d;
  logic [3:0]      err_q, err_d;
  logic [15:0]     rlen_q, rlen_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic cmd_pop;
  logic dat_rd;
  logic abort;
  logic expire;
  logic is_imm;
  logic cmd_bad;

  assign is_imm  = (bus.cmd_rdata_i[2:0] == 3'd1);
  assign cmd_bad = (bus.cmd_rdata_i[2:0] > 3'd1) || (int'(bus.cmd_rdata_i[20:16]) >= DatDepth);
  assign expire  = (TimeoutCycles > 0) && (cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    attr_d    = attr_q;
    tid_d     = tid_q;
    ccc_d     = ccc_q;
    cp_d      = cp_q;
    dev_idx_d = dev_idx_q;
    rnw_d     = rnw_q;
    roc_d     = roc_q;
    len_d     = len_q;
    imm_d     = imm_q;
    addr_d    = addr_q;
    i2c_d     = i2c_q;
    err_d     = err_q;
    rlen_d    = rlen_q;
    cnt_d     = cnt_q;
    cmd_pop   = 1'b0;
    dat_rd    = 1'b0;
    abort     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rvalid_i) begin
          cmd_pop   = 1'b1;
          attr_d    = bus.cmd_rdata_i[2:0];
          tid_d     = bus.cmd_rdata_i[6:3];
          ccc_d     = bus.cmd_rdata_i[14:7];
          cp_d      = bus.cmd_rdata_i[15];
          dev_idx_d = bus.cmd_rdata_i[20:16];
          roc_d     = bus.cmd_rdata_i[30];
          // Immediate transfers are always writes carrying at most four data bytes.
          if (is_imm) begin
            rnw_d = 1'b0;
            len_d = (bus.cmd_rdata_i[25:23] > 3'd4) ? 16'd4 : {13'd0, bus.cmd_rdata_i[25:23]};
            imm_d = bus.cmd_rdata_i[63:32];
          end else begin
            rnw_d = bus.cmd_rdata_i[29];
            len_d = bus.cmd_rdata_i[63:48];
            imm_d = 32'd0;
          end
          if (cmd_bad) begin
            err_d   = 4'hC;
            rlen_d  = 16'd0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_DAT_RD;
          end
        end
      end
      ST_DAT_RD: begin
        dat_rd  = 1'b1;
        state_d = ST_DAT_WAIT;
      end
      ST_DAT_WAIT: begin
        i2c_d   = bus.dat_rdata_i[31];
        addr_d  = bus.dat_rdata_i[31] ? bus.dat_rdata_i[6:0] : bus.dat_rdata_i[22:16];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.xfer_ready_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A completion arriving on the expiry cycle takes priority over the abort.
        if (bus.done_valid_i) begin
          err_d   = bus.done_err_i;
          rlen_d  = bus.done_len_i;
          state_d = ST_RESP;
        end else if (expire) begin
          abort   = 1'b1;
          err_d   = 4'h8;
          rlen_d  = 16'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if ((err_q == 4'd0) && !roc_q) begin
          state_d = ST_IDLE;
        end else if (bus.resp_wready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      attr_q    <= '0;
      tid_q     <= '0;
      ccc_q     <= '0;
      cp_q      <= 1'b0;
      dev_idx_q <= '0;
      rnw_q     <= 1'b0;
      roc_q     <= 1'b0;
      len_q     <= '0;
      imm_q     <= '0;
      addr_q    <= '0;
      i2c_q     <= 1'b0;
      err_q     <= '0;
      rlen_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      attr_q    <= attr_d;
      tid_q     <= tid_d;
      ccc_q     <= ccc_d;
      cp_q      <= cp_d;
      dev_idx_q <= dev_idx_d;
      rnw_q     <= rnw_d;
      roc_q     <= roc_d;
      len_q     <= len_d;
      imm_q     <= imm_d;
      addr_q    <= addr_d;
      i2c_q     <= i2c_d;
      err_q     <= err_d;
      rlen_q    <= rlen_d;
      cnt_q     <= cnt_d;
    end
  end

  logic issue;
  logic push;
  assign issue = (state_q == ST_ISSUE);
  assign push  = (state_q == ST_RESP) && ((err_q != 4'd0) || roc_q);

  // The pop is combinational, so it is blocked while reset is held to avoid losing a command.
  assign bus.cmd_rready_o     = cmd_pop & ~rst_i;
  assign bus.dat_read_valid_o = dat_rd;
  assign bus.dat_index_o      = dat_rd ? DatIdxW'(dev_idx_q) : '0;
  assign bus.xfer_valid_o     = issue;
  assign bus.xfer_attr_o      = issue ? attr_q : '0;
  assign bus.xfer_tid_o       = issue ? tid_q  : '0;
  assign bus.xfer_addr_o      = issue ? addr_q : '0;
  assign bus.xfer_i2c_o       = issue & i2c_q;
  assign bus.xfer_rnw_o       = issue & rnw_q;
  assign bus.xfer_cp_o        = issue & cp_q;
  assign bus.xfer_ccc_o       = issue ? ccc_q : '0;
  assign bus.xfer_len_o       = issue ? len_q : '0;
  assign bus.xfer_imm_o       = issue ? imm_q : '0;
  assign bus.xfer_abort_o     = abort;
  assign bus.resp_wvalid_o    = push;
  assign bus.resp_wdata_o     = push ? {err_q, tid_q, 8'h00, rlen_q} : '0;
  assign bus.busy_o           = (state_q != ST_IDLE);

  logic unused_bits;
  assign unused_bits = ^{bus.cmd_rdata_i[31], bus.cmd_rdata_i[28:26], bus.cmd_rdata_i[22:21],
                         bus.dat_rdata_i[63:32], bus.dat_rdata_i[30:23], bus.dat_rdata_i[15:7]};

endmodule

// File: tb/tb_hci_cmd_dispatch.sv
// Self-checking bench for hci_cmd_dispatch: directed scenarios plus randomized
// commands compared against a transaction-level reference model.
module tb_hci_cmd_dispatch;

  localparam int DAT_DEPTH = 16;
  localparam int TIMEOUT   = 16;

  typedef struct packed {
    logic [2:0]  attr;
    logic [3:0]  tid;
    logic [6:0]  addr;
    logic        i2c;
    logic        rnw;
    logic        cp;
    logic [7:0]  ccc;
    logic [15:0] len;
    logic [31:0] imm;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared   = 0;
  int   nMismatched = 0;
  logic [63:0] datMem [0:DAT_DEPTH-1];

  hci_cmd_dispatch_if #(.DatIdxW(4)) bus ();

  hci_cmd_dispatch #(.DatDepth(DAT_DEPTH), .TimeoutCycles(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // DAT memory returns the addressed entry on the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.dat_read_valid_o) bus.dat_rdata_i <= datMem[bus.dat_index_o];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic xfer_t obsXfer();
    return {bus.xfer_attr_o, bus.xfer_tid_o, bus.xfer_addr_o, bus.xfer_i2c_o, bus.xfer_rnw_o,
            bus.xfer_cp_o, bus.xfer_ccc_o, bus.xfer_len_o, bus.xfer_imm_o};
  endfunction

  function automatic logic [127:0] allOuts();
    return {bus.cmd_rready_o, bus.dat_read_valid_o, bus.dat_index_o, bus.xfer_valid_o, obsXfer(),
            bus.xfer_abort_o, bus.resp_wvalid_o, bus.resp_wdata_o, bus.busy_o};
  endfunction

  function automatic logic [63:0] mkCmd(input int attr, input int tid, input int dev, input int rnw,
                                        input int roc, input int dtt, input int cp, input int ccc,
                                        input logic [31:0] hi);
    return {hi, 1'b0, 1'(roc), 1'(rnw), 3'd0, 3'(dtt), 2'd0, 5'(dev), 1'(cp), 8'(ccc), 4'(tid), 3'(attr)};
  endfunction

  // Transfer the controller should see for a well-formed command and its DAT entry.
  function automatic xfer_t refXfer(input logic [63:0] cmd, input logic [63:0] dat);
    xfer_t x;
    int    dtt;
    x.attr = cmd[2:0];
    x.tid  = cmd[6:3];
    x.ccc  = cmd[14:7];
    x.cp   = cmd[15];
    x.i2c  = dat[31];
    x.addr = dat[31] ? dat[6:0] : dat[22:16];
    if (cmd[2:0] == 3'd1) begin
      dtt   = int'(cmd[25:23]);
      x.len = 16'((dtt < 4) ? dtt : 4);
      x.imm = cmd[63:32];
      x.rnw = 1'b0;
    end else begin
      x.len = cmd[63:48];
      x.imm = 32'd0;
      x.rnw = cmd[29];
    end
    return x;
  endfunction

  function automatic logic [31:0] respWord(input int err, input int tid, input int len);
    return 32'(err * (2 ** 28) + tid * (2 ** 24) + len);
  endfunction

  // One complete command: pop, DAT lookup, issue, completion (doneDly<0 = never), response.
  task automatic applyStimulus(input logic [63:0] cmd, input int xferDly, input int doneDly,
                               input logic [3:0] dErr, input logic [15:0] dLen,
                               input int respDly, input bit holdRv);
    xfer_t expX;
    logic  bad;
    int    expErr;
    int    expLen;
    logic  expPush;
    int    seen;
    int    guard;
    int    dev;
    dev = int'(cmd[20:16]);
    bad = (cmd[2:0] > 3'd1) || (dev >= DAT_DEPTH);
    expX = '0;
    if (!bad) expX = refXfer(cmd, datMem[dev]);
    guard = 0;
    while (bus.busy_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.cmd_rvalid_i = 1'b1;
    bus.cmd_rdata_i  = cmd;
    #1;
    checkOutput("pop_pulse", bus.cmd_rready_o, 1);
    @(negedge clk);
    if (!holdRv) bus.cmd_rvalid_i = 1'b0;
    else checkOutput("no_pop_busy", bus.cmd_rready_o, 0);
    if (bad) begin
      checkOutput("bad_no_dat", {bus.dat_read_valid_o, bus.xfer_valid_o}, 0);
      expErr = 12;
      expLen = 0;
    end else begin
      checkOutput("dat_strobe", {bus.dat_read_valid_o, bus.dat_index_o}, {1'b1, 4'(dev)});
      @(negedge clk);
      checkOutput("no_early_xfer", bus.xfer_valid_o, 0);
      @(negedge clk);
      checkOutput("xfer_issue", {bus.xfer_valid_o, obsXfer()}, {1'b1, expX});
      for (int i = 0; i < xferDly; i++) begin
        @(negedge clk);
        checkOutput("xfer_hold", {bus.xfer_valid_o, obsXfer()}, {1'b1, expX});
        if (holdRv) checkOutput("no_pop_busy", bus.cmd_rready_o, 0);
      end
      bus.xfer_ready_i = 1'b1;
      @(negedge clk);
      bus.xfer_ready_i = 1'b0;
      checkOutput("xfer_dropped", bus.xfer_valid_o, 0);
      if (doneDly >= 0) begin
        for (int i = 0; i < doneDly; i++) begin
          checkOutput("no_abort", bus.xfer_abort_o, 0);
          @(negedge clk);
        end
        bus.done_valid_i = 1'b1;
        bus.done_err_i   = dErr;
        bus.done_len_i   = dLen;
        #1;
        checkOutput("done_beats_abort", bus.xfer_abort_o, 0);
        @(negedge clk);
        bus.done_valid_i = 1'b0;
        expErr = int'(dErr);
        expLen = int'(dLen);
      end else begin
        seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
          if (bus.xfer_abort_o) seen = i;
          @(negedge clk);
        end
        checkOutput("abort_cycle", seen, TIMEOUT - 1);
        checkOutput("abort_pulse_end", bus.xfer_abort_o, 0);
        expErr = 8;
        expLen = 0;
      end
    end
    expPush = (expErr != 0) || cmd[30];
    if (expPush) begin
      checkOutput("resp_word", {bus.resp_wvalid_o, bus.resp_wdata_o},
                  {1'b1, respWord(expErr, int'(cmd[6:3]), expLen)});
      for (int i = 0; i < respDly; i++) begin
        @(negedge clk);
        checkOutput("resp_hold", {bus.resp_wvalid_o, bus.resp_wdata_o},
                    {1'b1, respWord(expErr, int'(cmd[6:3]), expLen)});
        if (holdRv) checkOutput("no_pop_busy", bus.cmd_rready_o, 0);
      end
      bus.resp_wready_i = 1'b1;
      bus.cmd_rvalid_i  = 1'b0;
      @(negedge clk);
      bus.resp_wready_i = 1'b0;
    end else begin
      checkOutput("no_resp_push", {bus.resp_wvalid_o, bus.busy_o}, {1'b0, 1'b1});
      @(negedge clk);
    end
    checkOutput("back_idle", {bus.busy_o, bus.resp_wvalid_o}, 0);
  endtask

  initial begin
    int r;
    int attr;
    int doneDly;
    logic [63:0] cmd;
    logic [3:0]  dErr;
    bus.cmd_rvalid_i  = 1'b0;
    bus.cmd_rdata_i   = '0;
    bus.dat_rdata_i   = '0;
    bus.xfer_ready_i  = 1'b0;
    bus.done_valid_i  = 1'b0;
    bus.done_err_i    = '0;
    bus.done_len_i    = '0;
    bus.resp_wready_i = 1'b0;
    for (int i = 0; i < DAT_DEPTH; i++) datMem[i] = {$urandom, $urandom};
    datMem[3] = 64'h0000_0000_002A_0000;
    datMem[7] = 64'h0000_0000_8011_0055;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOuts(), 0);
    rst = 1'b0;

    applyStimulus(mkCmd(0, 5, 3, 1, 1, 0, 0, 0, 32'h0010_0000), 0, 2, 4'h0, 16'd16, 0, 1'b0);
    applyStimulus(mkCmd(1, 6, 3, 0, 0, 6, 0, 0, 32'hDDCC_BBAA), 1, 3, 4'h0, 16'd4, 0, 1'b0);
    applyStimulus(mkCmd(3, 2, 3, 0, 0, 0, 0, 0, 32'h1234_5678), 0, 0, 4'h0, 16'd0, 0, 1'b0);
    applyStimulus(mkCmd(0, 9, 7, 0, 1, 0, 1, 8'h9A, 32'h0100_0000), 0, -1, 4'h0, 16'd0, 2, 1'b0);
    applyStimulus(mkCmd(0, 4, 3, 1, 1, 0, 0, 0, 32'h0020_0000), 10, 1, 4'h0, 16'd32, 10, 1'b1);
    applyStimulus(mkCmd(0, 1, 16, 1, 0, 0, 0, 0, 32'h0004_0000), 0, 0, 4'h0, 16'd0, 0, 1'b0);
    applyStimulus(mkCmd(0, 3, 15, 0, 0, 0, 0, 0, 32'h0008_0000), 0, 15, 4'h0, 16'd8, 0, 1'b0);
    applyStimulus(mkCmd(1, 7, 7, 1, 0, 4, 0, 8'h55, 32'hCAFE_F00D), 0, 14, 4'h3, 16'd2, 1, 1'b0);
    applyStimulus(mkCmd(1, 8, 2, 0, 1, 5, 1, 8'h07, 32'h0BAD_BEEF), 2, 0, 4'h0, 16'd4, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      attr = (r < 4) ? 0 : ((r < 8) ? 1 : $urandom_range(2, 7));
      cmd = {$urandom, $urandom};
      cmd[2:0]   = 3'(attr);
      cmd[20:16] = 5'($urandom_range(0, 19));
      r = $urandom_range(0, 9);
      doneDly = (r == 0) ? -1 : ((r == 1) ? 15 : $urandom_range(0, 8));
      dErr = ($urandom_range(0, 9) < 5) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus(cmd, $urandom_range(0, 5), doneDly, dErr, 16'($urandom),
                    $urandom_range(0, 4), 1'b0);
    end

    // Reset while waiting for completion: everything clears and a stale done is ignored.
    @(negedge clk);
    bus.cmd_rvalid_i = 1'b1;
    bus.cmd_rdata_i  = mkCmd(0, 10, 3, 1, 1, 0, 0, 0, 32'h0040_0000);
    @(negedge clk);
    bus.cmd_rvalid_i = 1'b0;
    for (int i = 0; i < 10 && !bus.xfer_valid_o; i++) @(negedge clk);
    checkOutput("rst_pre_issue", bus.xfer_valid_o, 1);
    bus.xfer_ready_i = 1'b1;
    @(negedge clk);
    bus.xfer_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_wait", allOuts(), 0);
    rst = 1'b0;
    bus.done_valid_i = 1'b1;
    bus.done_err_i   = 4'h5;
    bus.done_len_i   = 16'h00FF;
    @(negedge clk);
    bus.done_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("late_done_ignored", {bus.busy_o, bus.resp_wvalid_o}, 0);
      @(negedge clk);
    end

    applyStimulus(mkCmd(0, 11, 3, 0, 1, 0, 0, 0, 32'h0003_0000), 0, 0, 4'h0, 16'd3, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
